reg_scoreboard: RTL

- Parametrised register-hazard scoreboard for the pipelined WISC core. It generalises the 3-to-8 select decode to N-to-2^N.
- Two one-hot decodes feed a bank of per-register pending-write counters:
  - the issue destination selects which counter increments;
  - the writeback destination selects which counter decrements.
- Sits in decode stage. Produces per-register busy bits and a stall for source operands that still have writes in flight.

---
 rtl/reg_scoreboard_if.sv | 34 +++
 rtl/reg_scoreboard.sv | 105 ++++++++++
 2 files changed

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue/writeback/operand-check bundle for reg_scoreboard
interface reg_scoreboard_if #(
   parameter int SEL_W = 3
);
   localparam int NUM_REGS = 2**SEL_W;

   logic                issue_en;
   logic [SEL_W-1:0]    issue_sel;
   logic                wb_en;
   logic [SEL_W-1:0]    wb_sel;
   logic                rs_chk;
   logic [SEL_W-1:0]    rs_sel;
   logic                rt_chk;
   logic [SEL_W-1:0]    rt_sel;
   logic                flush;
   logic                stall;
   logic                issue_ack;
   logic [NUM_REGS-1:0] busy;
   logic                err_uflow;

   // Decode-stage side: drives requests, observes hazard results.
   modport master (
      output issue_en, issue_sel, wb_en, wb_sel,
      output rs_chk, rs_sel, rt_chk, rt_sel, flush,
      input  stall, issue_ack, busy, err_uflow
   );

   // Scoreboard side.
   modport slave (
      input  issue_en, issue_sel, wb_en, wb_sel,
      input  rs_chk, rs_sel, rt_chk, rt_sel, flush,
      output stall, issue_ack, busy, err_uflow
   );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write scoreboard; optional SCB_WB_BYPASS_EN
module reg_scoreboard #(
   parameter int SEL_W    = 3,
   parameter int MAX_PEND = 3,
   parameter int CNT_W    = 3
) (
   input logic              clk,
   input logic              rst_n,
   reg_scoreboard_if.slave  bus
);
   localparam int NUM_REGS = 2**SEL_W;
   localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_PEND);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_ZERO = '0;

   logic [CNT_W-1:0]    r_cnt      [NUM_REGS];
   logic [CNT_W-1:0]    w_cnt_nxt  [NUM_REGS];
   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] w_busy_nxt;
   logic [NUM_REGS-1:0] w_iss_oh;
   logic [NUM_REGS-1:0] w_wb_oh;
   logic                r_err_uflow;
   logic                w_uflow;
   logic                w_rs_haz;
   logic                w_rt_haz;
   logic                w_sat_haz;
   logic                w_stall;
   logic                w_issue_ack;

   // Hazard evaluation from registered state and raw inputs only, so issue_ack
   // never feeds back into stall.
   always_comb begin
      w_rs_haz = bus.rs_chk & r_busy[bus.rs_sel];
      w_rt_haz = bus.rt_chk & r_busy[bus.rt_sel];
`ifdef SCB_WB_BYPASS_EN
      // The last outstanding write commits this cycle and the register file
      // forwards its data, so the reader may proceed.
      w_rs_haz = w_rs_haz & ~(bus.wb_en & (bus.wb_sel == bus.rs_sel) &
                              (r_cnt[bus.rs_sel] == C_ONE));
      w_rt_haz = w_rt_haz & ~(bus.wb_en & (bus.wb_sel == bus.rt_sel) &
                              (r_cnt[bus.rt_sel] == C_ONE));
`endif
      // A saturated destination may still issue if a write to it retires now.
      w_sat_haz = bus.issue_en & (r_cnt[bus.issue_sel] == C_MAX) &
                  ~(bus.wb_en & (bus.wb_sel == bus.issue_sel));
      w_stall     = w_rs_haz | w_rt_haz | w_sat_haz;
      w_issue_ack = bus.issue_en & ~w_stall;
   end

   // One-hot decode of accepted issue and writeback destinations.
   always_comb begin
      w_iss_oh = '0;
      w_wb_oh  = '0;
      w_iss_oh[bus.issue_sel] = w_issue_ack;
      w_wb_oh[bus.wb_sel]     = bus.wb_en;
   end

   // Next counter values: flush wins, matched issue+writeback cancel out.
   always_comb begin
      w_uflow = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         if (bus.flush) begin
            w_cnt_nxt[i] = C_ZERO;
         end else begin
            case ({w_iss_oh[i], w_wb_oh[i]})
               2'b10: w_cnt_nxt[i] = r_cnt[i] + C_ONE;
               2'b01: begin
                  if (r_cnt[i] != C_ZERO) begin
                     w_cnt_nxt[i] = r_cnt[i] - C_ONE;
                  end else begin
                     w_uflow = 1'b1;
                  end
               end
               default: w_cnt_nxt[i] = r_cnt[i];
            endcase
         end
         w_busy_nxt[i] = (w_cnt_nxt[i] != C_ZERO);
      end
   end

   // Counter bank, busy vector and sticky underflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_cnt[i] <= C_ZERO;
         end
         r_busy      <= '0;
         r_err_uflow <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
         r_busy <= w_busy_nxt;
         if (w_uflow) begin
            r_err_uflow <= 1'b1;
         end
      end
   end

   assign bus.stall     = w_stall;
   assign bus.issue_ack = w_issue_ack;
   assign bus.busy      = r_busy;
   assign bus.err_uflow = r_err_uflow;
endmodule
